// File: rtl/add_bne_station_pkg.sv
// Shared types and constants for the add/bne Tomasulo execution cluster.
// Holds the operator codes, the reservation-station entry layout and the ALU helper.
package add_bne_station_pkg;

   localparam int TAG_W = 4;

   localparam logic [2:0] OP_ALU   = 3'd1;
   localparam logic [2:0] OP_LOAD  = 3'd2;
   localparam logic [2:0] OP_STORE = 3'd3;
   localparam logic [2:0] OP_BNE   = 3'd4;

   localparam logic [1:0] ALU_ADD = 2'd0;
   localparam logic [1:0] ALU_SUB = 2'd1;

   typedef struct packed {
      logic             valid;
      logic [1:0]       op;
      logic [31:0]      data1;
      logic [31:0]      data2;
      logic [TAG_W-1:0] q1;
      logic [TAG_W-1:0] q2;
      logic [TAG_W-1:0] dest;
      logic [31:0]      pc;
   } rs_entry_t;

   function automatic logic [31:0] alu_result(input logic [1:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
      logic [31:0] res;
      case (op)
         ALU_SUB: res = a - b;
         ALU_ADD: res = a + b;
         default: res = a + b;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/add_bne_station_cdb_bus.sv
// Add-result common data bus: a plain combinational fan-out of the add dispatch register.
module cdb_bus
   import add_bne_station_pkg::*;
#(
   parameter int TAG_W = 4
) (
   input  logic             enable,
   input  logic [TAG_W-1:0] robNum,
   input  logic [31:0]      data,
   output logic             iscast_out,
   output logic [TAG_W-1:0] robNum_out,
   output logic [31:0]      data_out
);

   assign iscast_out = enable;
   assign robNum_out = robNum;
   assign data_out   = data;

endmodule

// File: rtl/add_bne_station.sv
// Tomasulo add/sub and bne reservation stations with the add-result CDB.
// Operands wake up from the add CDB and the load CDB; results are registered at dispatch.
module add_bne_station
   import add_bne_station_pkg::*;
#(
   parameter int TAG_W       = 4,
   parameter int ADD_ENTRIES = 3,
   parameter int BNE_ENTRIES = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             funcUnitEnable,
   input  logic [2:0]       operatorType,
   input  logic [1:0]       operatorSubType,
   input  logic             operatorFlag,
   input  logic [TAG_W-1:0] robNum,
   input  logic [31:0]      pcNumber,
   input  logic [31:0]      data1,
   input  logic [31:0]      data2,
   input  logic [TAG_W-1:0] q1,
   input  logic [TAG_W-1:0] q2,
   output logic [TAG_W-1:0] index1,
   output logic [TAG_W-1:0] index2,
   input  logic             robReady1,
   input  logic [31:0]      robValue1,
   input  logic             robReady2,
   input  logic [31:0]      robValue2,
   input  logic             lwIscast,
   input  logic [TAG_W-1:0] lwRobNum,
   input  logic [31:0]      lwData,
   output logic             addAvailable,
   output logic             bneAvailable,
   output logic             cdbIscast,
   output logic [TAG_W-1:0] cdbRobNum,
   output logic [31:0]      cdbData,
   output logic             bneResultEnable,
   output logic [TAG_W-1:0] bneRobNum,
   output logic             bneData,
   output logic [31:0]      bnePc
);

   localparam int AIW = (ADD_ENTRIES > 1) ? $clog2(ADD_ENTRIES) : 1;
   localparam int BIW = (BNE_ENTRIES > 1) ? $clog2(BNE_ENTRIES) : 1;
   localparam logic [TAG_W-1:0] NO_TAG = {TAG_W{1'b0}};

   rs_entry_t        r_add [ADD_ENTRIES];
   rs_entry_t        r_bne [BNE_ENTRIES];
   logic             r_cdb_en;
   logic [TAG_W-1:0] r_cdb_tag;
   logic [31:0]      r_cdb_data;
   logic             r_bne_en;
   logic [TAG_W-1:0] r_bne_tag;
   logic             r_bne_taken;
   logic [31:0]      r_bne_pc;

   logic             w_add_free_ok;
   logic             w_add_disp_ok;
   logic [AIW-1:0]   w_add_free_idx;
   logic [AIW-1:0]   w_add_disp_idx;
   logic             w_bne_free_ok;
   logic             w_bne_disp_ok;
   logic [BIW-1:0]   w_bne_free_idx;
   logic [BIW-1:0]   w_bne_disp_idx;
   logic             w_add_issue;
   logic             w_bne_issue;
   logic [TAG_W+31:0] w_opnd1;
   logic [TAG_W+31:0] w_opnd2;
   rs_entry_t        w_new;
   rs_entry_t        w_add_head;
   rs_entry_t        w_bne_head;

   // Same-cycle bypass: add CDB beats load CDB, which beats the ROB; q==0 keeps the regfile value.
   function automatic logic [TAG_W+31:0] resolve(input logic [TAG_W-1:0] q,
                                                 input logic [31:0]      d,
                                                 input logic             rob_rdy,
                                                 input logic [31:0]      rob_val);
      logic [TAG_W+31:0] res;
      if (q == NO_TAG) begin
         res = {NO_TAG, d};
      end else if (r_cdb_en && (r_cdb_tag == q)) begin
         res = {NO_TAG, r_cdb_data};
      end else if (lwIscast && (lwRobNum == q)) begin
         res = {NO_TAG, lwData};
      end else if (rob_rdy) begin
         res = {NO_TAG, rob_val};
      end else begin
         res = {q, d};
      end
      return res;
   endfunction

   function automatic rs_entry_t wake(input rs_entry_t e);
      rs_entry_t n;
      n = e;
      if (e.valid && (e.q1 != NO_TAG) && r_cdb_en && (e.q1 == r_cdb_tag)) begin
         n.data1 = r_cdb_data;
         n.q1    = NO_TAG;
      end else if (e.valid && (e.q1 != NO_TAG) && lwIscast && (e.q1 == lwRobNum)) begin
         n.data1 = lwData;
         n.q1    = NO_TAG;
      end else begin
         n.q1    = e.q1;
      end
      if (e.valid && (e.q2 != NO_TAG) && r_cdb_en && (e.q2 == r_cdb_tag)) begin
         n.data2 = r_cdb_data;
         n.q2    = NO_TAG;
      end else if (e.valid && (e.q2 != NO_TAG) && lwIscast && (e.q2 == lwRobNum)) begin
         n.data2 = lwData;
         n.q2    = NO_TAG;
      end else begin
         n.q2    = e.q2;
      end
      return n;
   endfunction

   assign index1  = q1;
   assign index2  = q2;
   assign w_opnd1 = resolve(q1, data1, robReady1, robValue1);
   assign w_opnd2 = operatorFlag ? {NO_TAG, data2} : resolve(q2, data2, robReady2, robValue2);

   // Build the entry that an issue this cycle would write.
   always_comb begin
      w_new       = '0;
      w_new.valid = 1'b1;
      w_new.op    = operatorSubType;
      w_new.q1    = w_opnd1[TAG_W+31:32];
      w_new.data1 = w_opnd1[31:0];
      w_new.q2    = w_opnd2[TAG_W+31:32];
      w_new.data2 = w_opnd2[31:0];
      w_new.dest  = robNum;
      w_new.pc    = pcNumber;
   end

   // Lowest-index free slot and lowest-index ready slot of each station (descending scan).
   always_comb begin
      w_add_free_ok  = 1'b0;
      w_add_free_idx = '0;
      w_add_disp_ok  = 1'b0;
      w_add_disp_idx = '0;
      for (int i = ADD_ENTRIES - 1; i >= 0; i--) begin
         w_add_free_ok  = w_add_free_ok | ~r_add[i].valid;
         w_add_free_idx = (~r_add[i].valid) ? AIW'(i) : w_add_free_idx;
         w_add_disp_ok  = w_add_disp_ok |
                          (r_add[i].valid && (r_add[i].q1 == NO_TAG) && (r_add[i].q2 == NO_TAG));
         w_add_disp_idx = (r_add[i].valid && (r_add[i].q1 == NO_TAG) && (r_add[i].q2 == NO_TAG))
                          ? AIW'(i) : w_add_disp_idx;
      end
      w_bne_free_ok  = 1'b0;
      w_bne_free_idx = '0;
      w_bne_disp_ok  = 1'b0;
      w_bne_disp_idx = '0;
      for (int i = BNE_ENTRIES - 1; i >= 0; i--) begin
         w_bne_free_ok  = w_bne_free_ok | ~r_bne[i].valid;
         w_bne_free_idx = (~r_bne[i].valid) ? BIW'(i) : w_bne_free_idx;
         w_bne_disp_ok  = w_bne_disp_ok |
                          (r_bne[i].valid && (r_bne[i].q1 == NO_TAG) && (r_bne[i].q2 == NO_TAG));
         w_bne_disp_idx = (r_bne[i].valid && (r_bne[i].q1 == NO_TAG) && (r_bne[i].q2 == NO_TAG))
                          ? BIW'(i) : w_bne_disp_idx;
      end
   end

   assign w_add_issue = funcUnitEnable && (operatorType == OP_ALU) && w_add_free_ok;
   assign w_bne_issue = funcUnitEnable && (operatorType == OP_BNE) && w_bne_free_ok;
   assign w_add_head  = r_add[w_add_disp_idx];
   assign w_bne_head  = r_bne[w_bne_disp_idx];

   // Station state and result registers; a slot freed by dispatch is only reusable next cycle.
   always_ff @(posedge clock) begin
      if (reset || flush) begin
         for (int i = 0; i < ADD_ENTRIES; i++) begin
            r_add[i] <= '0;
         end
         for (int i = 0; i < BNE_ENTRIES; i++) begin
            r_bne[i] <= '0;
         end
         r_cdb_en    <= 1'b0;
         r_cdb_tag   <= NO_TAG;
         r_cdb_data  <= 32'd0;
         r_bne_en    <= 1'b0;
         r_bne_tag   <= NO_TAG;
         r_bne_taken <= 1'b0;
         r_bne_pc    <= 32'd0;
      end else begin
         for (int i = 0; i < ADD_ENTRIES; i++) begin
            r_add[i] <= wake(r_add[i]);
         end
         for (int i = 0; i < BNE_ENTRIES; i++) begin
            r_bne[i] <= wake(r_bne[i]);
         end
         if (w_add_disp_ok) begin
            r_add[w_add_disp_idx].valid <= 1'b0;
         end
         if (w_bne_disp_ok) begin
            r_bne[w_bne_disp_idx].valid <= 1'b0;
         end
         if (w_add_issue) begin
            r_add[w_add_free_idx] <= w_new;
         end
         if (w_bne_issue) begin
            r_bne[w_bne_free_idx] <= w_new;
         end
         r_cdb_en    <= w_add_disp_ok;
         r_cdb_tag   <= w_add_disp_ok ? w_add_head.dest : NO_TAG;
         r_cdb_data  <= w_add_disp_ok ?
                        alu_result(w_add_head.op, w_add_head.data1, w_add_head.data2) : 32'd0;
         r_bne_en    <= w_bne_disp_ok;
         r_bne_tag   <= w_bne_disp_ok ? w_bne_head.dest : NO_TAG;
         r_bne_taken <= w_bne_disp_ok && (w_bne_head.data1 != w_bne_head.data2);
         r_bne_pc    <= w_bne_disp_ok ? w_bne_head.pc : 32'd0;
      end
   end

   assign addAvailable    = w_add_free_ok;
   assign bneAvailable    = w_bne_free_ok;
   assign bneResultEnable = r_bne_en;
   assign bneRobNum       = r_bne_tag;
   assign bneData         = r_bne_taken;
   assign bnePc           = r_bne_pc;

   cdb_bus #(
      .TAG_W(TAG_W)
   ) u_cdb_bus (
      .enable     (r_cdb_en),
      .robNum     (r_cdb_tag),
      .data       (r_cdb_data),
      .iscast_out (cdbIscast),
      .robNum_out (cdbRobNum),
      .data_out   (cdbData)
   );

endmodule

// File: tb/tb_add_bne_station.sv
// Bench for add_bne_station: directed scenarios, then random traffic against an instruction-level model.
module tb_add_bne_station;

   logic        clock = 1'b0;
   logic        reset, flush, funcUnitEnable, operatorFlag;
   logic [2:0]  operatorType;
   logic [1:0]  operatorSubType;
   logic [3:0]  robNum, q1, q2, index1, index2, lwRobNum, cdbRobNum, bneRobNum;
   logic [31:0] pcNumber, data1, data2, robValue1, robValue2, lwData, cdbData, bnePc;
   logic        robReady1, robReady2, lwIscast, addAvailable, bneAvailable;
   logic        cdbIscast, bneResultEnable, bneData;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clock = ~clock;

   add_bne_station #(.TAG_W(4), .ADD_ENTRIES(3), .BNE_ENTRIES(2)) dut (
      .clock(clock), .reset(reset), .flush(flush), .funcUnitEnable(funcUnitEnable),
      .operatorType(operatorType), .operatorSubType(operatorSubType), .operatorFlag(operatorFlag),
      .robNum(robNum), .pcNumber(pcNumber), .data1(data1), .data2(data2), .q1(q1), .q2(q2),
      .index1(index1), .index2(index2), .robReady1(robReady1), .robValue1(robValue1),
      .robReady2(robReady2), .robValue2(robValue2), .lwIscast(lwIscast), .lwRobNum(lwRobNum),
      .lwData(lwData), .addAvailable(addAvailable), .bneAvailable(bneAvailable),
      .cdbIscast(cdbIscast), .cdbRobNum(cdbRobNum), .cdbData(cdbData),
      .bneResultEnable(bneResultEnable), .bneRobNum(bneRobNum), .bneData(bneData), .bnePc(bnePc)
   );

   // Instruction-level model: an instruction waits on producer tags and leaves when both are known.
   typedef struct {
      bit          v;
      bit          sub;
      logic [31:0] a, b, pc;
      logic [3:0]  wa, wb, dest;
   } instr_t;

   instr_t      m_add [3];
   instr_t      m_bne [2];
   bit          e_cdb, e_bne, e_taken;
   logic [3:0]  e_cdb_tag, e_bne_tag;
   logic [31:0] e_cdb_data, e_bne_pc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_in();
      flush = 1'b0; funcUnitEnable = 1'b0; operatorType = 3'd0; operatorSubType = 2'd0;
      operatorFlag = 1'b0; robNum = 4'd0; pcNumber = 32'd0; data1 = 32'd0; data2 = 32'd0;
      q1 = 4'd0; q2 = 4'd0; robReady1 = 1'b0; robValue1 = 32'd0; robReady2 = 1'b0;
      robValue2 = 32'd0; lwIscast = 1'b0; lwRobNum = 4'd0; lwData = 32'd0;
   endtask

   task automatic issue(input logic [2:0] typ, input logic [1:0] sub, input logic flg,
                        input logic [31:0] a, input logic [3:0] qa, input logic [31:0] b,
                        input logic [3:0] qb, input logic [3:0] tag, input logic [31:0] pc);
      funcUnitEnable = 1'b1; operatorType = typ; operatorSubType = sub; operatorFlag = flg;
      data1 = a; q1 = qa; data2 = b; q2 = qb; robNum = tag; pcNumber = pc;
   endtask

   // Value of an operand as seen on this cycle's buses; returns whether it is known.
   function automatic bit lookup(input logic [3:0] w, input logic [31:0] rf, input logic rdy,
                                 input logic [31:0] rv, output logic [31:0] val);
      bit known = 1'b1;
      if (w == 4'd0) val = rf;
      else if (e_cdb && e_cdb_tag == w) val = e_cdb_data;
      else if (lwIscast && lwRobNum == w) val = lwData;
      else if (rdy) val = rv;
      else begin val = rf; known = 1'b0; end
      return known;
   endfunction

   function automatic instr_t snoop(input instr_t x);
      instr_t y = x;
      logic [31:0] v;
      if (x.v && x.wa != 4'd0 && lookup(x.wa, x.a, 1'b0, 32'd0, v)) begin y.a = v; y.wa = 4'd0; end
      if (x.v && x.wb != 4'd0 && lookup(x.wb, x.b, 1'b0, 32'd0, v)) begin y.b = v; y.wb = 4'd0; end
      return y;
   endfunction

   task automatic model_step();
      int ra = -1, rb = -1, fa = -1, fb = -1;
      instr_t n;
      logic [31:0] v;
      bit n_cdb = 1'b0, n_bne = 1'b0, n_taken = 1'b0;
      logic [3:0] n_ctag = 4'd0, n_btag = 4'd0;
      logic [31:0] n_cdata = 32'd0, n_bpc = 32'd0;
      if (flush) begin
         foreach (m_add[i]) m_add[i].v = 1'b0;
         foreach (m_bne[i]) m_bne[i].v = 1'b0;
      end else begin
         for (int i = 2; i >= 0; i--) begin
            if (m_add[i].v && m_add[i].wa == 4'd0 && m_add[i].wb == 4'd0) ra = i;
            if (!m_add[i].v) fa = i;
         end
         for (int i = 1; i >= 0; i--) begin
            if (m_bne[i].v && m_bne[i].wa == 4'd0 && m_bne[i].wb == 4'd0) rb = i;
            if (!m_bne[i].v) fb = i;
         end
         if (ra >= 0) begin
            n_cdb = 1'b1; n_ctag = m_add[ra].dest;
            n_cdata = m_add[ra].sub ? m_add[ra].a - m_add[ra].b : m_add[ra].a + m_add[ra].b;
         end
         if (rb >= 0) begin
            n_bne = 1'b1; n_btag = m_bne[rb].dest; n_bpc = m_bne[rb].pc;
            n_taken = (m_bne[rb].a != m_bne[rb].b);
         end
         foreach (m_add[i]) m_add[i] = snoop(m_add[i]);
         foreach (m_bne[i]) m_bne[i] = snoop(m_bne[i]);
         if (ra >= 0) m_add[ra].v = 1'b0;
         if (rb >= 0) m_bne[rb].v = 1'b0;
         n.v = 1'b1; n.sub = (operatorSubType == 2'd1); n.pc = pcNumber; n.dest = robNum;
         n.wa = lookup(q1, data1, robReady1, robValue1, v) ? 4'd0 : q1;
         n.a = v;
         if (operatorFlag) begin n.b = data2; n.wb = 4'd0; end
         else begin
            n.wb = lookup(q2, data2, robReady2, robValue2, v) ? 4'd0 : q2;
            n.b = v;
         end
         if (funcUnitEnable && operatorType == 3'd1 && fa >= 0) m_add[fa] = n;
         if (funcUnitEnable && operatorType == 3'd4 && fb >= 0) m_bne[fb] = n;
      end
      e_cdb = n_cdb; e_cdb_tag = n_ctag; e_cdb_data = n_cdata;
      e_bne = n_bne; e_bne_tag = n_btag; e_bne_pc = n_bpc; e_taken = n_taken;
   endtask

   task automatic rand_inputs();
      int t = $urandom_range(0, 4);
      funcUnitEnable = ($urandom_range(0, 3) != 0);
      operatorType = (t < 2) ? 3'd1 : ((t < 4) ? 3'd4 : 3'd2);
      operatorSubType = 2'($urandom_range(0, 1));
      operatorFlag = ($urandom_range(0, 3) == 0);
      robNum = 4'($urandom_range(1, 7));
      pcNumber = $urandom; data1 = $urandom;
      data2 = ($urandom_range(0, 1) == 1) ? $urandom : data1;
      q1 = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(8, 15));
      q2 = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(8, 15));
      robReady1 = ($urandom_range(0, 3) == 0); robValue1 = $urandom;
      robReady2 = ($urandom_range(0, 3) == 0); robValue2 = $urandom;
      lwIscast = ($urandom_range(0, 2) == 0); lwRobNum = 4'($urandom_range(8, 15));
      lwData = $urandom;
      flush = ($urandom_range(0, 39) == 0);
   endtask

   initial begin
      clear_in(); reset = 1'b1;
      tick(); tick();
      chk("rst_cdb_en", 32'(cdbIscast), 32'd0);
      chk("rst_cdb_tag", 32'(cdbRobNum), 32'd0);
      chk("rst_cdb_data", cdbData, 32'd0);
      chk("rst_bne_en", 32'(bneResultEnable), 32'd0);
      chk("rst_bne_pc", bnePc, 32'd0);
      chk("rst_add_avail", 32'(addAvailable), 32'd1);
      chk("rst_bne_avail", 32'(bneAvailable), 32'd1);
      reset = 1'b0;

      issue(3'd1, 2'd0, 1'b0, 32'd5, 4'd0, 32'd7, 4'd0, 4'd3, 32'd0);
      tick(); clear_in();
      chk("add_early", 32'(cdbIscast), 32'd0);
      chk("add_avail_held", 32'(addAvailable), 32'd1);
      tick();
      chk("add_en", 32'(cdbIscast), 32'd1);
      chk("add_tag", 32'(cdbRobNum), 32'd3);
      chk("add_data", cdbData, 32'd12);
      tick();
      chk("add_pulse", 32'(cdbIscast), 32'd0);

      issue(3'd1, 2'd1, 1'b0, 32'hdead, 4'd2, 32'd30, 4'd0, 4'd4, 32'd0);
      tick(); clear_in();
      chk("index1_comb", 32'(index1), 32'd0);
      tick();
      chk("sub_wait", 32'(cdbIscast), 32'd0);
      lwIscast = 1'b1; lwRobNum = 4'd2; lwData = 32'd100;
      tick(); clear_in();
      chk("sub_capture", 32'(cdbIscast), 32'd0);
      tick();
      chk("sub_en", 32'(cdbIscast), 32'd1);
      chk("sub_tag", 32'(cdbRobNum), 32'd4);
      chk("sub_data", cdbData, 32'd70);

      issue(3'd4, 2'd0, 1'b0, 32'd4, 4'd0, 32'd4, 4'd0, 4'd5, 32'h20);
      tick(); clear_in(); tick();
      chk("bne_eq_en", 32'(bneResultEnable), 32'd1);
      chk("bne_eq_tag", 32'(bneRobNum), 32'd5);
      chk("bne_eq_data", 32'(bneData), 32'd0);
      chk("bne_eq_pc", bnePc, 32'h20);
      issue(3'd4, 2'd0, 1'b0, 32'd4, 4'd0, 32'd9, 4'd0, 4'd6, 32'h24);
      tick(); clear_in(); tick();
      chk("bne_ne_data", 32'(bneData), 32'd1);
      chk("bne_ne_pc", bnePc, 32'h24);

      issue(3'd1, 2'd0, 1'b0, 32'd4, 4'd0, 32'd5, 4'd0, 4'd6, 32'd0);
      tick(); clear_in(); tick();
      chk("byp_src_data", cdbData, 32'd9);
      issue(3'd1, 2'd0, 1'b1, 32'h0bad, 4'd6, 32'd1, 4'd0, 4'd7, 32'd0);
      tick(); clear_in();
      chk("byp_gap", 32'(cdbIscast), 32'd0);
      tick();
      chk("byp_en", 32'(cdbIscast), 32'd1);
      chk("byp_tag", 32'(cdbRobNum), 32'd7);
      chk("byp_data", cdbData, 32'd10);

      for (int i = 1; i <= 3; i++) begin
         issue(3'd1, 2'd0, 1'b0, 32'd0, 4'd9, 32'd1, 4'd0, 4'(i), 32'd0);
         tick();
      end
      clear_in();
      chk("full_avail", 32'(addAvailable), 32'd0);
      issue(3'd1, 2'd0, 1'b0, 32'd1, 4'd0, 32'd1, 4'd0, 4'd4, 32'd0);
      tick(); clear_in(); tick();
      chk("full_ignored", 32'(cdbIscast), 32'd0);
      flush = 1'b1;
      issue(3'd4, 2'd0, 1'b0, 32'd1, 4'd0, 32'd2, 4'd0, 4'd8, 32'h80);
      tick(); clear_in();
      chk("flush_avail", 32'(addAvailable), 32'd1);
      chk("flush_cdb", 32'(cdbIscast), 32'd0);
      lwIscast = 1'b1; lwRobNum = 4'd9; lwData = 32'd5;
      tick(); clear_in();
      chk("flush_beats_issue", 32'(bneResultEnable), 32'd0);
      tick();
      chk("flush_no_wake", 32'(cdbIscast), 32'd0);

      issue(3'd1, 2'd0, 1'b0, 32'd0, 4'd9, 32'd3, 4'd0, 4'd1, 32'd0);
      tick();
      issue(3'd4, 2'd0, 1'b0, 32'd1, 4'd0, 32'd2, 4'd0, 4'd2, 32'h40);
      tick(); clear_in();
      reset = 1'b1;
      tick(); reset = 1'b0;
      chk("mid_rst_bne_en", 32'(bneResultEnable), 32'd0);
      chk("mid_rst_bne_pc", bnePc, 32'd0);
      chk("mid_rst_bne_tag", 32'(bneRobNum), 32'd0);
      chk("mid_rst_add_avail", 32'(addAvailable), 32'd1);
      chk("mid_rst_bne_avail", 32'(bneAvailable), 32'd1);
      lwIscast = 1'b1; lwRobNum = 4'd9; lwData = 32'd5;
      tick(); clear_in(); tick();
      chk("mid_rst_no_wake", 32'(cdbIscast), 32'd0);

      reset = 1'b1; tick(); reset = 1'b0;
      foreach (m_add[i]) m_add[i].v = 1'b0;
      foreach (m_bne[i]) m_bne[i].v = 1'b0;
      e_cdb = 1'b0; e_bne = 1'b0; e_cdb_tag = 4'd0; e_bne_tag = 4'd0;
      e_cdb_data = 32'd0; e_bne_pc = 32'd0; e_taken = 1'b0;
      for (int c = 0; c < 400; c++) begin
         rand_inputs();
         chk("rnd_index2", 32'(index2), 32'(q2));
         model_step();
         tick();
         chk("rnd_cdb_en", 32'(cdbIscast), 32'(e_cdb));
         if (e_cdb) begin
            chk("rnd_cdb_tag", 32'(cdbRobNum), 32'(e_cdb_tag));
            chk("rnd_cdb_data", cdbData, e_cdb_data);
         end
         chk("rnd_bne_en", 32'(bneResultEnable), 32'(e_bne));
         if (e_bne) begin
            chk("rnd_bne_tag", 32'(bneRobNum), 32'(e_bne_tag));
            chk("rnd_bne_taken", 32'(bneData), 32'(e_taken));
            chk("rnd_bne_pc", bnePc, e_bne_pc);
         end
         chk("rnd_add_avail", 32'(addAvailable),
             32'(!(m_add[0].v && m_add[1].v && m_add[2].v)));
         chk("rnd_bne_avail", 32'(bneAvailable), 32'(!(m_bne[0].v && m_bne[1].v)));
      end
      clear_in();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
